// File: rtl/eth_tx_arb_pkg.sv
// Shared types and helpers for the Ethernet TX frame arbiter.
// Latency: n/a (types, constants and a combinational search function).
// Backpressure: n/a.
package eth_tx_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_GRANT     = 2'd1,
      ST_WAIT_DONE = 2'd2
   } arb_state_t;

   localparam int TIMEOUT_CNT_W = 16;

   // Search space of rr_next; narrower request vectors are zero-padded so the
   // modulo-8 wrap behaves exactly like a modulo-PORTS wrap.
   localparam int MAX_PORTS = 8;
   localparam int MAX_SEL_W = 3;

   // Round-robin search: first requester after 'last', wrapping, 'last' itself checked last.
   function automatic logic [MAX_SEL_W-1:0] rr_next(input logic [MAX_PORTS-1:0] req,
                                                    input logic [MAX_SEL_W-1:0] last);
      logic [MAX_SEL_W-1:0] idx;
      logic [MAX_SEL_W-1:0] win;
      logic                 found;
      win   = last;
      found = 1'b0;
      for (int k = 1; k <= MAX_PORTS; k++) begin
         idx = last + MAX_SEL_W'(k);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/eth_tx_arb_pick.sv
// Winner select for the TX frame arbiter (round-robin, or strict priority under ETH_TX_ARB_STRICT_PRIO_EN).
// Latency: purely combinational.
// Backpressure: none; the caller decides when to sample the winner.
module eth_tx_arb_pick
   import eth_tx_arb_pkg::*;
#(
   parameter int PORTS     = 2,
   parameter int SEL_WIDTH = $clog2(PORTS)
) (
   input  logic [PORTS-1:0]     req_i,
   input  logic [SEL_WIDTH-1:0] last_port_i,
   output logic [SEL_WIDTH-1:0] winner_o,
   output logic                 any_req_o
);

   logic [MAX_PORTS-1:0] req_pad;
   logic [MAX_SEL_W-1:0] win_pad;

   // Pick the winning source from the current request vector.
   always_comb begin
      req_pad = MAX_PORTS'(req_i);
`ifdef ETH_TX_ARB_STRICT_PRIO_EN
      // Searching after the top index always starts at port 0: lowest index wins.
      win_pad = rr_next(req_pad, MAX_SEL_W'(MAX_PORTS - 1));
`else
      win_pad = rr_next(req_pad, MAX_SEL_W'(last_port_i));
`endif
      winner_o  = SEL_WIDTH'(win_pad);
      any_req_o = |req_i;
   end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular arbiter sharing one MAC TX stream among PORTS AXI4-Stream sources; ETH_TX_ARB_STRICT_PRIO_EN selects strict priority.
// Latency: grant one cycle after a request is seen in IDLE; data path is a zero-latency mux.
// Backpressure: m_axis_tready passes straight to the granted source; next grant waits for tx_done or timeout.
module eth_tx_frame_arbiter
   import eth_tx_arb_pkg::*;
#(
   parameter int PORTS        = 2,
   parameter int DATA_WIDTH   = 8,
   parameter int USER_WIDTH   = 1,
   parameter int DONE_TIMEOUT = 4096,
   parameter int SEL_WIDTH    = $clog2(PORTS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
   input  logic [PORTS-1:0]             s_axis_tvalid,
   output logic [PORTS-1:0]             s_axis_tready,
   input  logic [PORTS-1:0]             s_axis_tlast,
   input  logic [PORTS*USER_WIDTH-1:0]  s_axis_tuser,
   output logic [DATA_WIDTH-1:0]        m_axis_tdata,
   output logic                         m_axis_tvalid,
   output logic                         m_axis_tlast,
   output logic [USER_WIDTH-1:0]        m_axis_tuser,
   input  logic                         m_axis_tready,
   input  logic                         tx_done,
   input  logic                         enable,
   output logic                         grant_valid,
   output logic [SEL_WIDTH-1:0]         grant_port,
   output logic                         timeout_err
);

   // Final count value in WAIT_DONE; unused when DONE_TIMEOUT is 0.
   localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CNT_W'(DONE_TIMEOUT - 1);

   arb_state_t                 state_q, state_d;
   logic [SEL_WIDTH-1:0]       grant_port_q, grant_port_d;
   logic [SEL_WIDTH-1:0]       last_port_q, last_port_d;
   logic [TIMEOUT_CNT_W-1:0]   cnt_q, cnt_d;
   logic                       timeout_err_q, timeout_err_d;

   logic [SEL_WIDTH-1:0]       winner;
   logic                       any_req;
   logic                       frame_end;

   eth_tx_arb_pick #(
      .PORTS     (PORTS),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_pick (
      .req_i       (s_axis_tvalid),
      .last_port_i (last_port_q),
      .winner_o    (winner),
      .any_req_o   (any_req)
   );

   // State, grant bookkeeping and timeout counter; last_port resets so port 0 wins first.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         grant_port_q  <= '0;
         last_port_q   <= SEL_WIDTH'(PORTS - 1);
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_port_q  <= grant_port_d;
         last_port_q   <= last_port_d;
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Next-state: grant in IDLE, leave GRANT on tlast handshake, leave WAIT_DONE on tx_done or timeout.
   always_comb begin
      state_d       = state_q;
      grant_port_d  = grant_port_q;
      last_port_d   = last_port_q;
      cnt_d         = '0;
      timeout_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable && any_req) begin
               grant_port_d = winner;
               last_port_d  = winner;
               state_d      = ST_GRANT;
            end
         end
         ST_GRANT: begin
            // tx_done and enable are deliberately not looked at: a frame is never cut short.
            if (frame_end) begin
               state_d = (DONE_TIMEOUT == 0) ? ST_IDLE : ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (tx_done) begin
               state_d = ST_IDLE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_d       = ST_IDLE;
               timeout_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Zero-latency pass-through of the granted source; everything is quiet outside GRANT.
   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = '0;
      s_axis_tready = '0;
      if (state_q == ST_GRANT) begin
         m_axis_tdata  = s_axis_tdata[int'(grant_port_q)*DATA_WIDTH +: DATA_WIDTH];
         m_axis_tvalid = s_axis_tvalid[grant_port_q];
         m_axis_tlast  = s_axis_tlast[grant_port_q];
         m_axis_tuser  = s_axis_tuser[int'(grant_port_q)*USER_WIDTH +: USER_WIDTH];
         s_axis_tready[grant_port_q] = m_axis_tready;
      end
      frame_end = m_axis_tvalid & m_axis_tready & m_axis_tlast;
   end

   assign grant_valid = (state_q == ST_GRANT);
   assign grant_port  = grant_port_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Scoreboard bench for eth_tx_frame_arbiter: PORTS=2, 8-bit data, DONE_TIMEOUT=16.
// Stimulus pushes expected beats, grants, timeout pulses and status snapshots into queues.
// A negedge monitor pops and compares whenever the DUT presents the matching output.
module tb_eth_tx_frame_arbiter;

   localparam int PORTS = 2;
   localparam int DW    = 8;
   localparam int TO    = 16;

   typedef struct { logic [7:0] data; logic last; logic user; } sbeat_t;
   typedef struct { logic [7:0] data; logic last; logic user; int port; int cyc; } ebeat_t;
   typedef struct { int cyc; int port; } gexp_t;
   typedef struct { int cyc; logic gv; logic mv; logic [1:0] rdy; logic to; } stat_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [PORTS*DW-1:0] s_tdata;
   logic [PORTS-1:0]  s_tvalid, s_tready, s_tlast, s_tuser;
   logic [DW-1:0]     m_tdata;
   logic              m_tvalid, m_tlast, m_tready;
   logic [0:0]        m_tuser;
   logic              tx_done, enable, grant_valid, timeout_err;
   logic [0:0]        grant_port;

   sbeat_t src_q0[$];
   sbeat_t src_q1[$];
   ebeat_t beat_q[$];
   gexp_t  gexp_q[$];
   int     to_q[$];
   stat_t  stat_q[$];

   logic [1:0] gap;
   logic [1:0] took;
   int cyc = 0;
   int errors = 0;
   int checks = 0;
   int n_tlast = 0;
   int last_tlast_cyc = 0;
   int m_cyc;

   eth_tx_frame_arbiter #(
      .PORTS(PORTS), .DATA_WIDTH(DW), .USER_WIDTH(1), .DONE_TIMEOUT(TO), .SEL_WIDTH(1)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
      .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
      .tx_done(tx_done), .enable(enable),
      .grant_valid(grant_valid), .grant_port(grant_port), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic drive_srcs();
      sbeat_t b;
      s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_tuser = '0;
      if (src_q0.size() > 0 && !gap[0]) begin
         b = src_q0[0];
         s_tvalid[0] = 1'b1; s_tdata[7:0] = b.data; s_tlast[0] = b.last; s_tuser[0] = b.user;
      end
      if (src_q1.size() > 0 && !gap[1]) begin
         b = src_q1[0];
         s_tvalid[1] = 1'b1; s_tdata[15:8] = b.data; s_tlast[1] = b.last; s_tuser[1] = b.user;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      took = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      if (took[0]) void'(src_q0.pop_front());
      if (took[1]) void'(src_q1.pop_front());
      drive_srcs();
   endtask

   task automatic src_frame(input int port, input int len, input logic [7:0] seed, input logic err);
      sbeat_t b;
      for (int k = 0; k < len; k++) begin
         b.data = seed + 8'(k);
         b.last = (k == len - 1);
         b.user = err && (k == len - 1);
         if (port == 0) src_q0.push_back(b); else src_q1.push_back(b);
      end
      drive_srcs();
   endtask

   task automatic exp_frame(input int port, input int len, input logic [7:0] seed, input logic err,
                            input int first_cyc);
      ebeat_t e;
      for (int k = 0; k < len; k++) begin
         e.data = seed + 8'(k);
         e.last = (k == len - 1);
         e.user = err && (k == len - 1);
         e.port = port;
         e.cyc  = (first_cyc < 0) ? -1 : first_cyc + k;
         beat_q.push_back(e);
      end
   endtask

   task automatic exp_grant(input int c, input int p);
      gexp_t g;
      g.cyc = c; g.port = p;
      gexp_q.push_back(g);
   endtask

   task automatic exp_stat(input int c, input logic gv, input logic mv, input logic [1:0] rdy,
                           input logic to);
      stat_t s;
      s.cyc = c; s.gv = gv; s.mv = mv; s.rdy = rdy; s.to = to;
      stat_q.push_back(s);
   endtask

   task automatic wait_tlast();
      int target = n_tlast + 1;
      int budget = 400;
      while (n_tlast < target && budget > 0) begin
         tick();
         budget--;
      end
      checks++;
      if (n_tlast < target) begin
         errors++;
         $display("FAIL tlast_wait: got %0d frames want %0d within budget", n_tlast, target);
      end
   endtask

   // Wait for the current frame to end, pulse tx_done two cycles later; next grant lands at K+2.
   task automatic finish_frame(input int next_port);
      wait_tlast();
      tick();
      tick();
      tx_done = 1'b1;
      if (next_port >= 0) exp_grant(cyc + 2, next_port);
      tick();
      tx_done = 1'b0;
   endtask

   // Monitor: every comparison against the DUT happens here.
   initial begin
      stat_t  st;
      ebeat_t eb;
      gexp_t  ge;
      int     tc;
      int     front_port;
      logic   gv_prev = 1'b0;
      logic [1:0] allowed;
      forever begin
         @(negedge clk);
         while (stat_q.size() > 0 && stat_q[0].cyc <= cyc) begin
            st = stat_q.pop_front();
            checks++;
            if (st.cyc != cyc || grant_valid !== st.gv || m_tvalid !== st.mv ||
                s_tready !== st.rdy || timeout_err !== st.to) begin
               errors++;
               $display("FAIL status@%0d: got gv=%b mv=%b rdy=%b to=%b want gv=%b mv=%b rdy=%b to=%b (cyc %0d)",
                        st.cyc, grant_valid, m_tvalid, s_tready, timeout_err,
                        st.gv, st.mv, st.rdy, st.to, cyc);
            end
         end
         front_port = (beat_q.size() > 0) ? beat_q[0].port : -1;
         allowed = (front_port == 0) ? 2'b01 : (front_port == 1) ? 2'b10 : 2'b00;
         checks++;
         if ((s_tready & ~allowed) != 2'b00) begin
            errors++;
            $display("FAIL idle_ready@%0d: got tready=%b want subset of %b", cyc, s_tready, allowed);
         end
         if (grant_valid && !gv_prev) begin
            checks++;
            if (gexp_q.size() == 0) begin
               errors++;
               $display("FAIL grant@%0d: got unexpected grant port %0d want no grant", cyc, grant_port);
            end else begin
               ge = gexp_q.pop_front();
               if (ge.cyc != cyc || int'(grant_port) != ge.port) begin
                  errors++;
                  $display("FAIL grant: got cyc=%0d port=%0d want cyc=%0d port=%0d",
                           cyc, grant_port, ge.cyc, ge.port);
               end
            end
         end
         if (m_tvalid && m_tready) begin
            checks++;
            if (beat_q.size() == 0) begin
               errors++;
               $display("FAIL beat@%0d: got unexpected data=%h want no beat", cyc, m_tdata);
            end else begin
               eb = beat_q.pop_front();
               if (m_tdata !== eb.data || m_tlast !== eb.last || m_tuser[0] !== eb.user ||
                   int'(grant_port) != eb.port || (eb.cyc >= 0 && eb.cyc != cyc)) begin
                  errors++;
                  $display("FAIL beat: got d=%h l=%b u=%b p=%0d cyc=%0d want d=%h l=%b u=%b p=%0d cyc=%0d",
                           m_tdata, m_tlast, m_tuser, grant_port, cyc,
                           eb.data, eb.last, eb.user, eb.port, eb.cyc);
               end
            end
            if (m_tlast) begin
               last_tlast_cyc = cyc;
               n_tlast++;
            end
         end
         if (timeout_err) begin
            checks++;
            if (to_q.size() == 0) begin
               errors++;
               $display("FAIL timeout@%0d: got unexpected timeout_err want 0", cyc);
            end else begin
               tc = to_q.pop_front();
               if (tc != cyc) begin
                  errors++;
                  $display("FAIL timeout: got cyc=%0d want cyc=%0d", cyc, tc);
               end
            end
         end
         gv_prev = grant_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion want finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; enable = 1'b1; tx_done = 1'b0; m_tready = 1'b1; gap = 2'b00;
      drive_srcs();
      repeat (3) tick();
      exp_stat(cyc, 1'b0, 1'b0, 2'b00, 1'b0);          // reset state
      tick();
      rst = 1'b0;

      // Both ports hold two 64-byte frames; B carries the error flag on its last beat.
      src_frame(0, 64, 8'h00, 1'b0);                   // A
      src_frame(1, 64, 8'h40, 1'b1);                   // B
      src_frame(0, 64, 8'h80, 1'b0);                   // C
      src_frame(1, 64, 8'hC0, 1'b0);                   // D
      exp_grant(cyc + 1, 0);
      exp_frame(0, 64, 8'h00, 1'b0, cyc + 1);
`ifdef ETH_TX_ARB_STRICT_PRIO_EN
      exp_frame(0, 64, 8'h80, 1'b0, -1);
      exp_frame(1, 64, 8'h40, 1'b1, -1);
      exp_frame(1, 64, 8'hC0, 1'b0, -1);
      finish_frame(0);
      finish_frame(1);
      finish_frame(1);
`else
      exp_frame(1, 64, 8'h40, 1'b1, -1);
      exp_frame(0, 64, 8'h80, 1'b0, -1);
      exp_frame(1, 64, 8'hC0, 1'b0, -1);
      finish_frame(1);
      finish_frame(0);
      finish_frame(1);
`endif
      finish_frame(-1);

      // Stray tx_done inside GRANT, then no tx_done: timeout 16 cycles into WAIT_DONE.
      src_frame(1, 8, 8'h10, 1'b0);                    // E
      exp_grant(cyc + 1, 1);
      exp_frame(1, 8, 8'h10, 1'b0, cyc + 1);
      tick();
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      wait_tlast();
      m_cyc = last_tlast_cyc;
      to_q.push_back(m_cyc + 17);
      src_frame(0, 10, 8'h20, 1'b0);                   // F, held off until the timeout
      src_frame(0, 16, 8'h30, 1'b0);                   // G, queued behind F
      exp_grant(m_cyc + 18, 0);
      exp_frame(0, 10, 8'h20, 1'b0, -1);
      exp_frame(0, 16, 8'h30, 1'b0, -1);

      // Source gap mid-frame passes through; enable drop does not abort F.
      while (cyc < m_cyc + 20) tick();
      gap[0] = 1'b1;
      drive_srcs();
      exp_stat(cyc, 1'b1, 1'b0, 2'b01, 1'b0);
      tick();
      tick();
      gap[0] = 1'b0;
      drive_srcs();
      tick();
      enable = 1'b0;
      wait_tlast();
      tick();
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      repeat (8) tick();
      exp_stat(cyc, 1'b0, 1'b0, 2'b00, 1'b0);          // G pending, enable low: no grant
      tick();
      enable = 1'b1;
      exp_grant(cyc + 1, 0);

      // Reset in the middle of G; last_port must return to PORTS-1.
      repeat (5) tick();
      rst = 1'b1;
      exp_stat(cyc + 1, 1'b0, 1'b0, 2'b00, 1'b0);
      tick();
      rst = 1'b0;
      src_q0.delete();
      beat_q.delete();
      drive_srcs();
      src_frame(0, 4, 8'h50, 1'b0);                    // H
      src_frame(1, 4, 8'h60, 1'b0);                    // I
      exp_grant(cyc + 1, 0);
      exp_frame(0, 4, 8'h50, 1'b0, cyc + 1);
      exp_frame(1, 4, 8'h60, 1'b0, -1);
      finish_frame(1);
      finish_frame(-1);
      repeat (4) tick();

      checks++;
      if (beat_q.size() != 0 || gexp_q.size() != 0 || to_q.size() != 0 || stat_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got beats=%0d grants=%0d timeouts=%0d status=%0d want all 0",
                  beat_q.size(), gexp_q.size(), to_q.size(), stat_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/eth_tx_frame_arbiter.md
# eth_tx_frame_arbiter

Frame-granular arbiter that shares the single GMII transmit MAC among several AXI4-Stream frame sources, for example ADC sample packets and control/ARP replies. It grants one source per frame and passes that frame through to the MAC AXI input with zero added latency. It then holds off the next grant until the MAC reports `tx_done`, so frames never interleave and inter-frame gaps are always honoured. It sits between the per-source frame FIFOs and the MAC TX input.

## Interface
Parameters:
- `PORTS`, 2: number of requesting sources, 2..8.
- `DATA_WIDTH`, 8: stream data width; must match the MAC.
- `USER_WIDTH`, 1: tuser width; bit 0 is the frame-error flag.
- `DONE_TIMEOUT`, 4096: maximum cycles spent in WAIT_DONE; 0 means no wait for `tx_done`.
- `SEL_WIDTH`, `$clog2(PORTS)`: grant index width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `s_axis_tdata` in PORTS*DATA_WIDTH: packed source data; port i occupies slice i.
- `s_axis_tvalid` in PORTS: per-source valid.
- `s_axis_tready` out PORTS: per-source ready.
- `s_axis_tlast` in PORTS: per-source end of frame.
- `s_axis_tuser` in PORTS*USER_WIDTH: per-source user bits, packed like tdata.
- `m_axis_tdata`, `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tuser` out: stream to the MAC.
- `m_axis_tready` in 1: MAC ready.
- `tx_done` in 1: MAC pulse at the end of the IFG.
- `enable` in 1: allows new grants.
- `grant_valid` out 1: a frame is granted (GRANT state).
- `grant_port` out SEL_WIDTH: index of the granted source.
- `timeout_err` out 1: one-cycle pulse when the WAIT_DONE timeout expires.

## Operation
- State machine: IDLE → GRANT → WAIT_DONE → IDLE.
- **IDLE:**
  - If `enable` is high and any `s_axis_tvalid` is high, pick a winner, register `grant_port`, and go to GRANT.
  - Otherwise stay in IDLE.
- **Arbitration (round-robin):** search starts at `last_port+1` modulo PORTS. The first port with tvalid high wins. `last_port` updates to the winner.
- **GRANT, combinational pass-through:**
  - `m_axis_*` = slice [grant_port] of the `s_axis_*` inputs.
  - `s_axis_tready[i]` = `m_axis_tready` when i==grant_port, else 0.
  - `m_axis_tvalid` = `s_axis_tvalid[grant_port]`.
  - A tvalid gap from the source is passed through unchanged. The MAC flags the underflow itself; the arbiter stays in GRANT until tlast.
- **Leaving GRANT:** a handshake (`m_axis_tvalid && m_axis_tready && m_axis_tlast`) moves to WAIT_DONE. If DONE_TIMEOUT==0 it moves to IDLE instead.
- **WAIT_DONE:**
  - A 16-bit counter counts from 0.
  - `tx_done` high → IDLE.
  - Counter reaching DONE_TIMEOUT-1 → pulse `timeout_err`, go to IDLE.
- **Ignored events:** `tx_done` in IDLE or GRANT is ignored. `enable` falling during GRANT or WAIT_DONE does not abort the current frame.
- **Outputs outside GRANT:** `m_axis_tvalid`=0, `m_axis_tdata`/`m_axis_tlast`/`m_axis_tuser`=0, and all `s_axis_tready`=0.
- **Reset values:**
  - state IDLE, `last_port`=PORTS-1 (so port 0 wins first), `grant_port`=0.
  - `grant_valid`=0, `timeout_err`=0, counter=0.
  - `m_axis_tvalid`=0 and all `s_axis_tready`=0.
- **Reset mid-frame:** the frame is truncated and the state returns to IDLE the next cycle. The MAC sees tvalid drop and handles it as underflow.

## Timing
- Requests seen in IDLE at cycle N → `grant_valid`/`grant_port` valid at N+1; the first beat can transfer at N+1.
- Data path latency is 0 cycles, with no bubbles inside a frame.
- Final tlast handshake at cycle M → WAIT_DONE from M+1.
- `tx_done` at cycle K → IDLE at K+1 → next grant at K+2.
- Minimum arbitration overhead is 2 cycles between the frame's tlast and the next grant, plus the MAC's FCS/IFG time.
- `timeout_err` asserts in the cycle the state enters IDLE via timeout.

## Configuration
- Macro `ETH_TX_ARB_STRICT_PRIO_EN`.
- Defined: strict priority. The lowest-index requesting port always wins, and `last_port` is unused.
- Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

## Structure
- Package `eth_tx_arb_pkg`:
  - state enum (`ST_IDLE`, `ST_GRANT`, `ST_WAIT_DONE`);
  - localparam `TIMEOUT_CNT_W`=16;
  - function `rr_next(req, last)`.
- Sub-module `eth_tx_arb_pick`: combinational winner select; inputs req and last_port, outputs winner and any_req. It is the only place the macro is tested.
- The top module holds the FSM, counter, muxes and output registers.

## Test plan
- **Round-robin:** PORTS=2, both ports hold 64-byte frames continuously → grants alternate 0,1,0,1. Each frame is byte-exact at the MAC, and there are no ready pulses on the idle port.
- **Strict priority:** ETH_TX_ARB_STRICT_PRIO_EN defined, port 0 always valid → port 1 is never granted while port 0 requests. After port 0 stops, port 1 is granted within 2 cycles of `tx_done`.
- **Hold-off:** `tx_done` held low, frame ends → no new grant. With DONE_TIMEOUT=16, `timeout_err` pulses exactly 16 cycles after entering WAIT_DONE, then the next grant follows.
- **Gaps and enable:** `enable` dropped mid-frame → the frame completes; no further grant until `enable` returns. A source tvalid gap mid-frame propagates unchanged to `m_axis_tvalid`.
- **Reset mid-frame:** `rst` asserted mid-frame → next cycle `m_axis_tvalid`=0, `grant_valid`=0, all tready 0; the first grant after reset goes to port 0.
- **Stray tx_done:** `tx_done` pulsed during GRANT → ignored, and WAIT_DONE is still entered after tlast.
